// File: rtl/silly_pkg.sv
// silly_freq_detect shared types, constants and the period classifier.
// Imported by the frequency-detector top and its helpers.
package silly_pkg;

  localparam int DEF_CNT_W = 10;

  typedef enum logic [0:0] {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam logic [3:0] CODE_NONE = 4'd0;

  // Walk k downward so the smallest matching k is the one kept.
  function automatic logic [3:0] period_to_code(
    input logic [31:0] p,
    input int unsigned tol
  );
    logic [3:0]  code;
    logic [31:0] ref_v;
    logic [31:0] diff;
    code = CODE_NONE;
    for (int k = 8; k >= 1; k--) begin
      ref_v = 32'd1 << k;
      diff  = (p > ref_v) ? (p - ref_v) : (ref_v - p);
      if (diff <= tol) begin
        code = 4'(k);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/silly_sync_edge.sv
// Two-flop synchronizer plus history flop for one async input.
// Produces the synchronized level and single-cycle rise/fall pulses.
module silly_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_in_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= sig_in_i;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = s2_q & ~hist_q;
  assign fall_o = ~s2_q & hist_q;

endmodule

// File: rtl/silly_freq_detect.sv
// Measures an async square wave's period and classifies it as clk/2^k.
// Optional high-time/duty measurement: define SILLY_DUTY_MEAS_EN.
module silly_freq_detect
  import silly_pkg::*;
#(
  parameter int          CNT_W          = DEF_CNT_W,
  parameter int          TIMEOUT_CYCLES = 600,
  parameter int          LOCK_COUNT     = 4,
  parameter int unsigned TOLERANCE      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_out,
  output logic [3:0]       ratio_code,
  output logic             locked,
  output logic             timeout,
  output logic [CNT_W-1:0] high_cycles,
  output logic             duty_ok
);

  localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);
  localparam logic [3:0]       LCK_V = 4'(LOCK_COUNT);

  logic sync_w;
  logic rise_w;
  logic fall_w;

  silly_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .sig_in_i (sig_in),
    .sync_o   (sync_w),
    .rise_o   (rise_w),
    .fall_o   (fall_w)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       lcnt_q, lcnt_d;
  logic             lock_q, lock_d;
  logic             mv_q, mv_d;
  logic             to_q, to_d;
  logic [3:0]       code_w;

  assign code_w = period_to_code(32'(cnt_q), TOLERANCE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEEK;
      cnt_q   <= '0;
      per_q   <= '0;
      code_q  <= CODE_NONE;
      lcnt_q  <= 4'd0;
      lock_q  <= 1'b0;
      mv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      code_q  <= code_d;
      lcnt_q  <= lcnt_d;
      lock_q  <= lock_d;
      mv_q    <= mv_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    code_d  = code_q;
    lcnt_d  = lcnt_q;
    lock_d  = lock_q;
    mv_d    = 1'b0;
    to_d    = 1'b0;
    if (!enable) begin
      state_d = SEEK;
      cnt_d   = '0;
      lcnt_d  = 4'd0;
      lock_d  = 1'b0;
      code_d  = CODE_NONE;
    end else begin
      unique case (state_q)
        SEEK: begin
          if (rise_w) begin
            state_d = MEASURE;
            cnt_d   = ONE_V;
          end
        end
        MEASURE: begin
          if (rise_w) begin
            cnt_d  = ONE_V;
            per_d  = cnt_q;
            code_d = code_w;
            mv_d   = 1'b1;
            if (code_w == CODE_NONE) begin
              lcnt_d = 4'd0;
              lock_d = 1'b0;
            end else if (code_w == code_q) begin
              if (lcnt_q != 4'hF) begin
                lcnt_d = lcnt_q + 4'd1;
              end
              if (lcnt_d >= LCK_V) begin
                lock_d = 1'b1;
              end
            end else begin
              lcnt_d = 4'd1;
              lock_d = 1'b0;
            end
          end else if (cnt_q >= TO_V) begin
            // Loss of signal: report once and re-arm from scratch.
            to_d    = 1'b1;
            lock_d  = 1'b0;
            code_d  = CODE_NONE;
            lcnt_d  = 4'd0;
            cnt_d   = '0;
            state_d = SEEK;
          end else begin
            cnt_d = cnt_q + ONE_V;
          end
        end
        default: begin
          state_d = SEEK;
        end
      endcase
    end
  end

  assign meas_valid = mv_q;
  assign period_out = per_q;
  assign ratio_code = code_q;
  assign locked     = lock_q;
  assign timeout    = to_q;

`ifdef SILLY_DUTY_MEAS_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] hcap_q, hcap_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic             duty_q, duty_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      hcap_q <= '0;
      hi_q   <= '0;
      duty_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      hcap_q <= hcap_d;
      hi_q   <= hi_d;
      duty_q <= duty_d;
    end
  end

  always_comb begin
    hcnt_d = hcnt_q;
    hcap_d = hcap_q;
    hi_d   = hi_q;
    duty_d = duty_q;
    if (!enable) begin
      hcnt_d = '0;
    end else begin
      if (rise_w) begin
        hcnt_d = ONE_V;
      end else if (sync_w && (hcnt_q != '1)) begin
        hcnt_d = hcnt_q + ONE_V;
      end
      if (fall_w) begin
        hcap_d = hcnt_q;
      end
    end
    // The capture from this period's fall pairs with the period now closing.
    if (mv_d) begin
      hi_d   = hcap_q;
      duty_d = ({hcap_q, 1'b0} == {1'b0, cnt_q});
    end
  end

  assign high_cycles = hi_q;
  assign duty_ok     = duty_q;
`else
  logic unused_edge;
  assign unused_edge = sync_w ^ fall_w;
  assign high_cycles = '0;
  assign duty_ok     = 1'b0;
`endif

endmodule

// File: tb/tb_silly_freq_detect.sv
// Directed bench for silly_freq_detect: table of waveform periods
// plus hand sequences for timeout, reset, enable and duty cases.
module tb_silly_freq_detect;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sig_in;
  logic          meas_valid;
  logic [CW-1:0] period_out;
  logic [3:0]    ratio_code;
  logic          locked;
  logic          timeout;
  logic [CW-1:0] high_cycles;
  logic          duty_ok;

  silly_freq_detect dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sig_in      (sig_in),
    .meas_valid  (meas_valid),
    .period_out  (period_out),
    .ratio_code  (ratio_code),
    .locked      (locked),
    .timeout     (timeout),
    .high_cycles (high_cycles),
    .duty_ok     (duty_ok)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int cyc      = 0;
  int mv_cnt   = 0;
  int to_cnt   = 0;
  int last_per = 0;
  int last_code = 0;
  int last_lock = 0;
  int last_hi  = 0;
  int last_duty = 0;
  int last_mv_cyc = 0;
  int last_to_cyc = 0;

  always @(posedge clk) begin
    #2;
    cyc += 1;
    if (meas_valid) begin
      mv_cnt += 1;
      last_per  = int'(period_out);
      last_code = int'(ratio_code);
      last_lock = int'(locked);
      last_hi   = int'(high_cycles);
      last_duty = int'(duty_ok);
      last_mv_cyc = cyc;
    end
    if (timeout) begin
      to_cnt += 1;
      last_to_cyc = cyc;
    end
  end

  typedef struct {
    int hi;
    int lo;
    int ev;
    int per;
    int code;
    int lck;
  } row_t;

  row_t rows[21];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int hi, input int lo);
    repeat (hi) begin
      sig_in = 1'b1;
      @(negedge clk);
    end
    repeat (lo) begin
      sig_in = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic meas_chk(input string nm, input int base, input int ev,
                          input int per, input int code, input int lck);
    chk({nm, "_mv"}, mv_cnt - base, ev);
    if (ev != 0) begin
      chk({nm, "_per"}, last_per, per);
      chk({nm, "_code"}, last_code, code);
      chk({nm, "_lock"}, last_lock, lck);
    end
  endtask

  initial begin
    int base;
    int tbase;

    rows[0]  = '{4, 4, 0, 0, 0, 0};
    rows[1]  = '{4, 4, 1, 8, 3, 0};
    rows[2]  = '{4, 4, 1, 8, 3, 0};
    rows[3]  = '{4, 4, 1, 8, 3, 0};
    rows[4]  = '{6, 6, 1, 8, 3, 1};
    rows[5]  = '{6, 6, 1, 12, 0, 0};
    rows[6]  = '{2, 2, 1, 12, 0, 0};
    rows[7]  = '{2, 2, 1, 4, 2, 0};
    rows[8]  = '{2, 2, 1, 4, 2, 0};
    rows[9]  = '{2, 2, 1, 4, 2, 0};
    rows[10] = '{8, 8, 1, 4, 2, 1};
    rows[11] = '{8, 8, 1, 16, 4, 0};
    rows[12] = '{8, 8, 1, 16, 4, 0};
    rows[13] = '{8, 8, 1, 16, 4, 0};
    rows[14] = '{1, 2, 1, 16, 4, 1};
    rows[15] = '{3, 3, 1, 3, 0, 0};
    rows[16] = '{60, 4, 1, 6, 0, 0};
    rows[17] = '{200, 56, 1, 64, 6, 0};
    rows[18] = '{2, 3, 1, 256, 8, 0};
    rows[19] = '{2, 3, 1, 5, 0, 0};
    rows[20] = '{1, 2, 1, 5, 0, 0};

    reset  = 1'b1;
    enable = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mv", int'(meas_valid), 0);
    chk("rst_per", int'(period_out), 0);
    chk("rst_code", int'(ratio_code), 0);
    chk("rst_lock", int'(locked), 0);
    chk("rst_to", int'(timeout), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 21; r++) begin
      base = mv_cnt;
      drive(rows[r].hi, rows[r].lo);
      meas_chk($sformatf("row%0d", r), base, rows[r].ev,
               rows[r].per, rows[r].code, rows[r].lck);
    end
    chk("table_no_to", to_cnt, 0);

    base = mv_cnt;
    repeat (4) drive(1, 1);
    drive(4, 4);
    meas_chk("div2", base, 5, 2, 1, 1);

    base = mv_cnt;
    repeat (4) drive(4, 4);
    meas_chk("relock8", base, 4, 8, 3, 1);

    tbase = to_cnt;
    for (int i = 0; i < 700 && to_cnt == tbase; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("to_pulses", to_cnt - tbase, 1);
    chk("to_dist", last_to_cyc - last_mv_cyc, 600);
    chk("to_lock", int'(locked), 0);
    chk("to_code", int'(ratio_code), 0);
    chk("to_per_hold", int'(period_out), 8);
    base = mv_cnt;
    drive(4, 4);
    meas_chk("to_rearm", base, 0, 0, 0, 0);
    base = mv_cnt;
    drive(4, 4);
    meas_chk("to_first", base, 1, 8, 3, 0);

    drive(4, 4);
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_mv", int'(meas_valid), 0);
    chk("mrst_per", int'(period_out), 0);
    chk("mrst_code", int'(ratio_code), 0);
    chk("mrst_lock", int'(locked), 0);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    base = mv_cnt;
    drive(4, 4);
    meas_chk("mrst_rearm", base, 0, 0, 0, 0);
    base = mv_cnt;
    drive(4, 4);
    meas_chk("mrst_first", base, 1, 8, 3, 0);

    base = mv_cnt;
    repeat (3) drive(4, 4);
    meas_chk("en_lock", base, 3, 8, 3, 1);
    base = mv_cnt;
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_mv", mv_cnt - base, 0);
    chk("en_code", int'(ratio_code), 0);
    chk("en_lock0", int'(locked), 0);
    chk("en_per_hold", int'(period_out), 8);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    base = mv_cnt;
    drive(4, 4);
    meas_chk("en_rearm", base, 0, 0, 0, 0);
    base = mv_cnt;
    drive(4, 4);
    meas_chk("en_first", base, 1, 8, 3, 0);

    tbase = to_cnt;
    base  = mv_cnt;
    drive(300, 300);
    drive(300, 300);
    drive(4, 4);
    meas_chk("edge600", base, 3, 600, 0, 0);
    chk("edge600_to", to_cnt - tbase, 0);

`ifdef SILLY_DUTY_MEAS_EN
    repeat (3) drive(3, 5);
    drive(4, 4);
    chk("duty35_per", last_per, 8);
    chk("duty35_hi", last_hi, 3);
    chk("duty35_ok", last_duty, 0);
    drive(4, 4);
    chk("duty44_per", last_per, 8);
    chk("duty44_hi", last_hi, 4);
    chk("duty44_ok", last_duty, 1);
`else
    repeat (2) drive(3, 5);
    chk("nodut_hi", last_hi, 0);
    chk("nodut_ok", last_duty, 0);
    chk("nodut_hi_port", int'(high_cycles), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/silly_freq_detect.md
Name: silly_freq_detect

Overview:
- Receive-side companion to the divided-clock generator. It takes one external, asynchronous square wave and measures its period in clk cycles.
- It classifies the period as a divide-by-2^k rate (k = 1..8) and declares lock after repeated consistent measurements.
- It sits at a chip input, so a divided clock looped back off-chip can be checked against the on-chip divider chain.

Parameters:
- CNT_W, 10, period counter width in bits.
- TIMEOUT_CYCLES, 600, clk cycles with no rising edge before loss of signal is declared; must be < 2^CNT_W and > 256.
- LOCK_COUNT, 4, number of consecutive equal nonzero codes required to assert locked; range 1..15.
- TOLERANCE, 0, allowed |period - 2^k| in cycles for a match; must be < 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  synchronous run enable.
- sig_in  in  1  external signal, asynchronous to clk.
- meas_valid  out  1  one-cycle pulse when a new measurement is presented.
- period_out  out  CNT_W  last measured period in clk cycles.
- ratio_code  out  4  k when period matches 2^k; 0 means no match.
- locked  out  1  stable-rate indication.
- timeout  out  1  one-cycle pulse on loss of signal.
- high_cycles  out  CNT_W  high time of the last period (optional feature).
- duty_ok  out  1  high time equals period/2 (optional feature).

Behaviour:
- Reset: asynchronous, active-high; clock is clk. On reset all outputs are 0, state = SEEK, counters = 0.
- Input path:
  - sig_in passes through a 2-flop synchronizer, then a 1-flop history register.
  - rise = sync2 & ~hist.
  - rise occurs 2 cycles after the first clk edge that samples sig_in high.
- Period counter cnt:
  - On a rise cycle, cnt <= 1.
  - Otherwise cnt <= cnt + 1, saturating at TIMEOUT_CYCLES.
  - The value seen at the next rise equals the rise-to-rise distance. Example: rises 2 cycles apart give period 2.
- FSM states:
  - SEEK:
    - Waits for the first rise; no measurement is produced.
    - rise -> MEASURE, cnt <= 1.
  - MEASURE, on each rise:
    - Register period_out <= cnt and ratio_code <= code(cnt).
    - Pulse meas_valid in the following cycle, so meas_valid is 3 clk after the sig_in sample.
    - Restart cnt.
  - MEASURE, timeout: if cnt reaches TIMEOUT_CYCLES with no rise, pulse timeout for 1 cycle, clear locked, ratio_code and lock_cnt, and go to SEEK. period_out holds its value.
- code(p): the smallest k in 1..8 with |p - 2^k| <= TOLERANCE, else 0. p is treated as unsigned; p = 1 gives 0.
- Lock logic, evaluated on each measurement:
  - Nonzero code equal to the previous code: lock_cnt increments (saturating). locked <= 1 when lock_cnt reaches LOCK_COUNT.
  - Nonzero code differing from the previous code: lock_cnt <= 1 and locked <= 0.
  - Code 0: lock_cnt <= 0 and locked <= 0.
  - locked changes in the same cycle as meas_valid.
- enable low: synchronously forces SEEK and clears the counters, locked and ratio_code. period_out holds. The synchronizer keeps running.
- Simultaneous events:
  - A rise in the same cycle that cnt reaches TIMEOUT_CYCLES counts as a rise; no timeout is raised.
  - enable low takes priority over a rise.
- Reset mid-measurement: returns to SEEK immediately. The first post-reset rise only starts a measurement.

Optional Feature:
- Macro: SILLY_DUTY_MEAS_EN.
- Defined:
  - A high-time counter restarts on rise, increments while sync2 is high, and is captured at the falling edge.
  - high_cycles is updated together with period_out.
  - duty_ok = (2 * high_cycles == period_out) and is valid with meas_valid.
- Undefined: high_cycles and duty_ok are tied to 0 and no counter logic is built. The ports remain.

Decomposition:
- Shared package silly_pkg holds:
  - CNT_W default;
  - the state enum {SEEK, MEASURE};
  - CODE_NONE = 4'd0;
  - the period_to_code function.
- One natural sub-module, silly_sync_edge: 2-flop synchronizer plus history flop, producing the rise and fall pulses.

Test Plan:
- Divide-by-8 square wave (4 high / 4 low), enable = 1:
  - first rise gives no meas_valid;
  - the next 4 rises each pulse meas_valid with period_out = 8 and ratio_code = 3;
  - locked rises with the 4th measurement.
- Period 12 (6/6): meas_valid with period_out = 12, ratio_code = 0, locked stays 0.
- Locked on divide-by-4, switch to divide-by-16:
  - first new measurement gives code 4 and locked -> 0;
  - relock after 4 measurements of period 16.
- Hold sig_in low after lock: timeout pulses exactly once, 600 cycles after the last rise; locked = 0 and ratio_code = 0; the next rise produces no meas_valid.
- Assert reset mid-period, and separately drop enable mid-period: outputs clear per spec and the first post-release rise only re-arms.
- With SILLY_DUTY_MEAS_EN defined, a 3-high / 5-low signal gives period_out = 8, high_cycles = 3, duty_ok = 0; a 4/4 signal gives duty_ok = 1.
